ex_branch_resolver: RTL and testbench

EX-stage consumer of the ID/EX register's branch fields; it produces that register's ID_FLUSH and predictor_val inputs. It resolves conditional-equal branches in EX, compares the outcome against the prediction carried down the pipe, and on a mispredict issues a registered PC redirect plus a multi-cycle flush. It owns a bimodal pattern history table (PHT) of 2-bit saturating counters, read combinationally by IF and updated by EX.

---
 rtl/branch_pkg.sv | 23 ++
 rtl/bimodal_pht.sv | 41 ++++
 rtl/ex_branch_resolver.sv | 101 ++++++++++
 tb/tb_ex_branch_resolver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared encodings and helpers for the EX-stage branch resolver
// Purpose: 2-bit bimodal counter encodings, reset value, PC step and
//          saturating counter helpers used by the PHT and the resolver.
// Ports:   none (package)
package branch_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] PHT_RESET = WNT;
   localparam int         PC_STEP   = 4;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == ST) ? ST : c + 2'b01;
   endfunction

   function automatic logic [1:0] sat_dec(input logic [1:0] c);
      return (c == SNT) ? SNT : c - 2'b01;
   endfunction

endpackage

// File: rtl/bimodal_pht.sv
// rtl/bimodal_pht.sv - bimodal pattern history table of 2-bit saturating counters
// Purpose: 2**PHT_IDX counters, one combinational read port for IF lookup,
//          one synchronous update port driven by EX resolution.
// Ports:   clk, rst          clock, asynchronous active-high reset
//          rd_idx, rd_data   combinational lookup (returns pre-update value)
//          upd_en, upd_idx,  update enable, index and resolved direction
//          upd_taken
module bimodal_pht
   import branch_pkg::*;
#(
   parameter int PHT_IDX = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PHT_IDX-1:0] rd_idx,
   output logic [1:0]         rd_data,
   input  logic               upd_en,
   input  logic [PHT_IDX-1:0] upd_idx,
   input  logic               upd_taken
);

   localparam int ENTRIES = 2**PHT_IDX;

   logic [1:0] table_q [ENTRIES];

   // Read straight from the array; a same-cycle update lands at the edge, so
   // the lookup sees the old counter until the next cycle.
   assign rd_data = table_q[rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= PHT_RESET;
         end
      end else if (upd_en) begin
         table_q[upd_idx] <= upd_taken ? sat_inc(table_q[upd_idx])
                                       : sat_dec(table_q[upd_idx]);
      end
   end

endmodule

// File: rtl/ex_branch_resolver.sv
// rtl/ex_branch_resolver.sv - EX-stage beq resolution, redirect, flush and PHT owner
// Purpose: resolves branch-if-equal in EX, compares against the carried
//          prediction, issues a registered redirect plus a multi-cycle flush
//          on mispredict, counts mispredicts and trains the bimodal PHT.
// Ports:   clk, rst                    clock, asynchronous active-high reset
//          pc_if, predict_taken_if     IF lookup and its prediction
//          if_beq_ex, predictor_ex     EX branch flag and carried prediction
//          data_1_ex, data_2_ex        compared operands
//          imm_ex, pc_ex               byte offset and PC of EX instruction
//          id_flush, if_flush          flush requests to ID/EX and IF/ID
//          redirect_valid, redirect_pc one-cycle redirect strobe and target
//          mispredict_count            saturating mispredict counter
module ex_branch_resolver
   import branch_pkg::*;
#(
   parameter int DATA_LEN     = 64,
   parameter int ADDRESS_SIZE = 6,
   parameter int PHT_IDX      = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_LEN      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2**ADDRESS_SIZE-1:0] pc_if,
   output logic                       predict_taken_if,
   input  logic                       if_beq_ex,
   input  logic                       predictor_ex,
   input  logic [DATA_LEN-1:0]        data_1_ex,
   input  logic [DATA_LEN-1:0]        data_2_ex,
   input  logic [DATA_LEN-1:0]        imm_ex,
   input  logic [2**ADDRESS_SIZE-1:0] pc_ex,
   output logic                       id_flush,
   output logic                       if_flush,
   output logic                       redirect_valid,
   output logic [2**ADDRESS_SIZE-1:0] redirect_pc,
   output logic [CNT_LEN-1:0]         mispredict_count
);

   localparam int PC_W = 2**ADDRESS_SIZE;

   logic [2:0]         flush_cnt;
   logic               resolve;
   logic               taken;
   logic               mispredict;
   logic [PC_W-1:0]    target;
   logic [PC_W-1:0]    fallthrough;
   logic [1:0]         pred_entry;
   logic [PHT_IDX-1:0] if_idx;
   logic [PHT_IDX-1:0] ex_idx;
   logic               unused_bits;

   // While the flush counter runs, EX holds a bubble and must not resolve.
   assign resolve     = if_beq_ex && (flush_cnt == 3'd0);
   assign taken       = (data_1_ex == data_2_ex);
   assign mispredict  = resolve && (taken != predictor_ex);
   assign target      = pc_ex + imm_ex[PC_W-1:0];
   assign fallthrough = pc_ex + PC_W'(PC_STEP);

   assign if_idx = pc_if[PHT_IDX+1:2];
   assign ex_idx = pc_ex[PHT_IDX+1:2];

   assign unused_bits = ^{pc_if[PC_W-1:PHT_IDX+2], pc_if[1:0]};

   bimodal_pht #(
      .PHT_IDX (PHT_IDX)
   ) u_pht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (if_idx),
      .rd_data   (pred_entry),
      .upd_en    (resolve),
      .upd_idx   (ex_idx),
      .upd_taken (taken)
   );

   assign predict_taken_if = pred_entry[1];

   assign id_flush = (flush_cnt != 3'd0);
   assign if_flush = (flush_cnt != 3'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt        <= 3'd0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         mispredict_count <= '0;
      end else begin
         redirect_valid <= mispredict;
         if (mispredict) begin
            redirect_pc <= taken ? target : fallthrough;
            flush_cnt   <= 3'(FLUSH_CYCLES);
            if (mispredict_count != {CNT_LEN{1'b1}}) begin
               mispredict_count <= mispredict_count + CNT_LEN'(1);
            end
         end else if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_ex_branch_resolver.sv
// tb/tb_ex_branch_resolver.sv - self-checking bench for ex_branch_resolver
module tb_ex_branch_resolver;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [63:0] pc_if;
   logic        if_beq_ex;
   logic        predictor_ex;
   logic [63:0] data_1_ex;
   logic [63:0] data_2_ex;
   logic [63:0] imm_ex;
   logic [63:0] pc_ex;

   logic        predict_taken_if, id_flush, if_flush, redirect_valid;
   logic [63:0] redirect_pc;
   logic [15:0] mispredict_count;

   // Second instance with a 2-bit mispredict counter to reach saturation quickly.
   logic        s_pred, s_idf, s_iff, s_rv;
   logic [63:0] s_rpc;
   logic [1:0]  s_cnt;

   ex_branch_resolver dut (
      .clk(clk), .rst(rst), .pc_if(pc_if), .predict_taken_if(predict_taken_if),
      .if_beq_ex(if_beq_ex), .predictor_ex(predictor_ex),
      .data_1_ex(data_1_ex), .data_2_ex(data_2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
      .id_flush(id_flush), .if_flush(if_flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
   );

   ex_branch_resolver #(.CNT_LEN(2)) dut_small (
      .clk(clk), .rst(rst), .pc_if(pc_if), .predict_taken_if(s_pred),
      .if_beq_ex(if_beq_ex), .predictor_ex(predictor_ex),
      .data_1_ex(data_1_ex), .data_2_ex(data_2_ex), .imm_ex(imm_ex), .pc_ex(pc_ex),
      .id_flush(s_idf), .if_flush(s_iff), .redirect_valid(s_rv),
      .redirect_pc(s_rpc), .mispredict_count(s_cnt)
   );

   // Reference model: counters as plain integers 0..3, flush as cycles remaining.
   int          m_pht [16];
   int          m_flush;
   bit          m_rv;
   logic [63:0] m_rpc;
   int          m_cnt;
   int          m_scnt;

   int checks = 0;
   int errors = 0;

   function automatic int idx_of(input logic [63:0] pc);
      return int'((pc >> 2) % 64'd16);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_pht[i] = 1;
      m_flush = 0;
      m_rv    = 0;
      m_rpc   = '0;
      m_cnt   = 0;
      m_scnt  = 0;
   endtask

   task automatic check_pred(input string tag);
      chk({tag, "_pred"},   {63'd0, predict_taken_if}, {63'd0, m_pht[idx_of(pc_if)] >= 2});
      chk({tag, "_s_pred"}, {63'd0, s_pred},           {63'd0, m_pht[idx_of(pc_if)] >= 2});
   endtask

   task automatic check_all(input string tag);
      check_pred(tag);
      chk({tag, "_id_flush"}, {63'd0, id_flush},       {63'd0, m_flush != 0});
      chk({tag, "_if_flush"}, {63'd0, if_flush},       {63'd0, m_flush != 0});
      chk({tag, "_rv"},       {63'd0, redirect_valid}, {63'd0, m_rv});
      chk({tag, "_rpc"},      redirect_pc,             m_rpc);
      chk({tag, "_cnt"},      {48'd0, mispredict_count}, 64'(m_cnt));
      chk({tag, "_s_flush"},  {62'd0, s_idf, s_iff},   {62'd0, m_flush != 0, m_flush != 0});
      chk({tag, "_s_rv"},     {63'd0, s_rv},           {63'd0, m_rv});
      chk({tag, "_s_rpc"},    s_rpc,                   m_rpc);
      chk({tag, "_s_cnt"},    {62'd0, s_cnt},          64'(m_scnt));
   endtask

   // Drive one cycle: inputs settle mid-cycle, prediction is checked before
   // the edge (old PHT contents), model advances, outputs checked after it.
   task automatic cycle(input string tag, input bit beq, input bit pred,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input logic [63:0] pcx,
                        input logic [63:0] pci);
      bit resolve, taken, mis;
      int i;
      if_beq_ex = beq; predictor_ex = pred; data_1_ex = d1; data_2_ex = d2;
      imm_ex = imm; pc_ex = pcx; pc_if = pci;
      #1;
      check_pred({tag, "_pre"});
      resolve = beq && (m_flush == 0);
      taken   = (d1 == d2);
      mis     = resolve && (taken != pred);
      @(posedge clk);
      m_rv = mis;
      if (mis) begin
         m_rpc   = taken ? pcx + imm : pcx + 64'd4;
         m_flush = 2;
         if (m_cnt < 65535) m_cnt++;
         if (m_scnt < 3) m_scnt++;
      end else if (m_flush > 0) begin
         m_flush--;
      end
      if (resolve) begin
         i = idx_of(pcx);
         if (taken && m_pht[i] < 3) m_pht[i]++;
         if (!taken && m_pht[i] > 0) m_pht[i]--;
      end
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic [63:0] pci);
      cycle(tag, 1'b0, 1'b0, 64'd0, 64'd1, 64'd0, 64'd0, pci);
   endtask

   initial begin
      logic [63:0] r1, r2, rp;
      bit          eq;
      rst = 1'b1;
      if_beq_ex = 0; predictor_ex = 0; data_1_ex = 0; data_2_ex = 0;
      imm_ex = 0; pc_ex = 0; pc_if = 64'h40;
      model_reset();
      #2;
      check_all("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_all("post_reset");

      // 1: reset with flush counter at 1 aborts everything immediately
      cycle("t1_mis", 1'b1, 1'b0, 64'd5, 64'd5, 64'h10, 64'h8, 64'h40);
      idle("t1_f2", 64'h40);
      #2; rst = 1'b1; #1;
      model_reset();
      check_all("t1_async_reset");
      chk("t1_pred_40", {63'd0, predict_taken_if}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_all("t1_held");

      // 2: taken mispredict at 0x100
      cycle("t2_mis", 1'b1, 1'b0, 64'hAB, 64'hAB, 64'h20, 64'h100, 64'h40);
      chk("t2_rpc_const", redirect_pc, 64'h120);
      chk("t2_cnt_const", {48'd0, mispredict_count}, 64'd1);
      idle("t2_f1", 64'h40);
      idle("t2_f2", 64'h40);
      idle("t2_done", 64'h100);
      chk("t2_pred_100", {63'd0, predict_taken_if}, 64'd1);

      // 3: correct not-taken at 0x104, twice
      cycle("t3_a", 1'b1, 1'b0, 64'd1, 64'd2, 64'h40, 64'h104, 64'h104);
      cycle("t3_b", 1'b1, 1'b0, 64'd1, 64'd2, 64'h40, 64'h104, 64'h104);
      chk("t3_rv_const", {63'd0, redirect_valid}, 64'd0);

      // 4: branches presented during the flush window are bubbles
      cycle("t4_mis", 1'b1, 1'b1, 64'd1, 64'd2, 64'h0, 64'h208, 64'h208);
      cycle("t4_b1", 1'b1, 1'b1, 64'd3, 64'd4, 64'h0, 64'h208, 64'h208);
      cycle("t4_b2", 1'b1, 1'b0, 64'd3, 64'd3, 64'h0, 64'h208, 64'h208);
      idle("t4_done", 64'h208);

      // 5: PC wrap-around for target and fall-through
      cycle("t5_taken", 1'b1, 1'b0, 64'd7, 64'd7, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      chk("t5_rpc_4", redirect_pc, 64'h4);
      idle("t5_f1", 64'h0);
      idle("t5_f2", 64'h0);
      cycle("t5_ntaken", 1'b1, 1'b1, 64'd7, 64'd6, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
      chk("t5_rpc_0", redirect_pc, 64'h0);
      idle("t5_f3", 64'h0);
      idle("t5_f4", 64'h0);

      // 6: saturation on the narrow counter; read-during-write on pc_if==pc_ex
      for (int k = 0; k < 3; k++) begin
         cycle("t6_mis", 1'b1, 1'b0, 64'd9, 64'd9, 64'h4, 64'h30, 64'h30);
         idle("t6_f1", 64'h30);
         idle("t6_f2", 64'h30);
      end
      chk("t6_sat", {62'd0, s_cnt}, 64'd3);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         r1 = {$urandom, $urandom};
         eq = $urandom_range(0, 1) == 1;
         r2 = eq ? r1 : {$urandom, $urandom};
         rp = {$urandom, $urandom} & ~64'h3;
         cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, r1, r2,
               {$urandom, $urandom}, rp,
               ($urandom_range(0, 1) == 1) ? rp : ({$urandom, $urandom} & ~64'h3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
